// File: rtl/fm_audio_pkg.sv
// Shared sample type and range constants for the FM audio decimator.
package fm_audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

endpackage

// File: rtl/fm_sample_fifo.sv
// Synchronous FIFO with registered head output and registered empty flag.
module fm_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             empty_q, empty_d;
  logic             wr_en;
  logic             rd_en;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = empty_q;
  assign dout  = dout_q;
  assign level = level_q;

  always_comb begin
    rd_en    = pop && !empty_q;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    wr_en    = push && (!full || rd_en);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    level_d = level_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    empty_d = (level_d == '0);
    dout_d  = dout_q;
    if (level_d != '0) begin
      dout_d = mem_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
      empty_q  <= empty_d;
    end
  end

endmodule

// File: rtl/fm_audio_decim.sv
// Accumulate-and-dump decimator feeding a small output FIFO with sticky overflow.
// FM_AUDIO_DECIM_ROUND_EN selects round-half-up with saturation instead of truncation.
module fm_audio_decim
  import fm_audio_pkg::*;
#(
  parameter int DECIM      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [15:0]                   fir_in,
  output logic [15:0]                   audio_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf
);

  localparam int SHIFT = $clog2(DECIM);
  localparam int ACC_W = SAMPLE_W + SHIFT;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] total;
  logic [SHIFT-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    dump;
  logic                    fifo_full;
  logic                    fifo_empty;
  sample_t                 result;

`ifdef FM_AUDIO_DECIM_ROUND_EN
  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT-1);
  logic signed [ACC_W:0]       rnd;
  logic signed [ACC_W-SHIFT:0] rq;
`endif

  always_comb begin
    total = acc_q + $signed({{SHIFT{fir_in[15]}}, fir_in});
    dump  = in_valid && (cnt_q == SHIFT'(DECIM-1));
`ifdef FM_AUDIO_DECIM_ROUND_EN
    rnd = $signed({total[ACC_W-1], total}) + HALF;
    rq  = rnd[ACC_W:SHIFT];
    if (rq > $signed({SAMPLE_MAX[SAMPLE_W-1], SAMPLE_MAX})) begin
      result = SAMPLE_MAX;
    end else if (rq < $signed({SAMPLE_MIN[SAMPLE_W-1], SAMPLE_MIN})) begin
      result = SAMPLE_MIN;
    end else begin
      result = rq[SAMPLE_W-1:0];
    end
`else
    // Upper slice of the sum is the floor division by DECIM.
    result = total[SHIFT +: SAMPLE_W];
`endif
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (in_valid) begin
      if (dump) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = total;
        cnt_d = cnt_q + SHIFT'(1);
      end
    end
    ovf_d = ovf_q || (dump && fifo_full && !out_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  fm_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (dump),
    .din   (result),
    .pop   (out_ready),
    .dout  (audio_out),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  assign out_valid = !fifo_empty;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fm_audio_decim.sv
// Scoreboard bench for fm_audio_decim with DECIM=4, FIFO_DEPTH=4.
module tb_fm_audio_decim;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] fir_in = '0;
  logic [15:0] audio_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  fifo_level;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  int          m_acc = 0;
  int          m_cnt = 0;
  bit          m_ovf = 1'b0;
  logic [15:0] exp_q[$];

  fm_audio_decim #(.DECIM(4), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .fir_in     (fir_in),
    .audio_out  (audio_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_result(input int t);
    int r;
`ifdef FM_AUDIO_DECIM_ROUND_EN
    r = (t + 2) >>> 2;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`else
    r = t >>> 2;
`endif
    return 16'(r);
  endfunction

  // One clock: scoreboard pop compare before the edge, model update, then edge.
  task automatic step(input bit v, input int x, input bit rdy);
    bit do_pop;
    int t;
    in_valid  = v;
    fir_in    = 16'(x);
    out_ready = rdy;
    do_pop = rdy && (exp_q.size() != 0);
    if (do_pop) begin
      total++;
      if (out_valid !== 1'b1 || audio_out !== exp_q[0]) begin
        bad++;
        $display("FAIL pop_data: got valid=%b data=%0d expected valid=1 data=%0d",
                 out_valid, $signed(audio_out), $signed(exp_q[0]));
      end
      void'(exp_q.pop_front());
    end
    if (v) begin
      if (m_cnt == 3) begin
        t = m_acc + x;
        if (exp_q.size() < 4) exp_q.push_back(model_result(t));
        else m_ovf = 1'b1;
        m_acc = 0;
        m_cnt = 0;
      end else begin
        m_acc += x;
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    exp_q.delete();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      step(1'b0, 0, 1'b1);
      cyc++;
    end
    total++;
    if (exp_q.size() != 0 || fifo_level !== 3'd0) begin
      bad++;
      $display("FAIL %s_drain: left=%0d level=%0d expected left=0 level=0",
               name, exp_q.size(), fifo_level);
    end
  endtask

  task automatic test_reset;
    in_valid = 1'b1;
    fir_in   = 16'd123;
    do_reset(2);
    in_valid = 1'b0;
    total += 4;
    if (audio_out !== 16'd0) begin bad++; $display("FAIL rst_audio: got %0d expected 0", audio_out); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    if (fifo_level !== 3'd0) begin bad++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
    if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
  endtask

  task automatic test_mid_reset;
    step(1'b1, 500, 1'b0);
    step(1'b1, 500, 1'b0);
    do_reset(1);
    repeat (4) step(1'b1, 8, 1'b0);
    total++;
    if (fifo_level !== 3'd1 || audio_out !== 16'd8) begin
      bad++;
      $display("FAIL midrst_out: got level=%0d data=%0d expected level=1 data=8", fifo_level, $signed(audio_out));
    end
    drain("midrst");
  endtask

  task automatic test_constant;
    step(1'b1, 1000, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b1, 1000, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b1, 1000, 1'b0);
    step(1'b0, 0, 1'b0);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL const_early: got valid=%b expected 0", out_valid); end
    step(1'b1, 1000, 1'b0);
    total++;
    if (out_valid !== 1'b1 || audio_out !== 16'd1000 || fifo_level !== 3'd1) begin
      bad++;
      $display("FAIL const_latency: got valid=%b data=%0d level=%0d expected 1 1000 1",
               out_valid, $signed(audio_out), fifo_level);
    end
    drain("const");
    total++;
    if (audio_out !== 16'd1000 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL const_hold: got valid=%b data=%0d expected 0 1000", out_valid, $signed(audio_out));
    end
  endtask

  task automatic test_rounding;
    step(1'b1, 1, 1'b0);
    step(1'b1, 1, 1'b0);
    step(1'b1, 1, 1'b0);
    step(1'b1, 0, 1'b0);
    repeat (4) step(1'b1, -1, 1'b0);
    total++;
    if (fifo_level !== 3'd2) begin bad++; $display("FAIL round_level: got %0d expected 2", fifo_level); end
    drain("round");
  endtask

  task automatic test_saturation;
    repeat (4) step(1'b1, 32767, 1'b0);
    repeat (4) step(1'b1, -32768, 1'b0);
    drain("sat");
  endtask

  task automatic test_overflow;
    for (int d = 1; d <= 5; d++) begin
      repeat (4) step(1'b1, 10 * d, 1'b0);
    end
    total += 2;
    if (fifo_level !== 3'd4) begin bad++; $display("FAIL ovf_level: got %0d expected 4", fifo_level); end
    if (ovf !== m_ovf || ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b expected 1", ovf); end
    drain("ovf");
    total++;
    if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
  endtask

  task automatic test_back_to_back;
    do_reset(1);
    for (int d = 1; d <= 4; d++) begin
      repeat (4) step(1'b1, 100 * d, 1'b0);
    end
    repeat (3) step(1'b1, 500, 1'b0);
    step(1'b1, 500, 1'b1);
    total += 2;
    if (fifo_level !== 3'd4) begin bad++; $display("FAIL b2b_level: got %0d expected 4", fifo_level); end
    if (ovf !== 1'b0 || m_ovf) begin bad++; $display("FAIL b2b_ovf: got %b expected 0", ovf); end
    drain("b2b");
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_mid_reset();
    test_constant();
    test_rounding();
    test_saturation();
    test_overflow();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
